// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: machine word, epoch colours, execute state and buffer entries.
package fetch_pkg;

    typedef logic [31:0] rvwordT;

    typedef enum logic [1:0] {
        EPOCH_RED     = 2'd0,
        EPOCH_GREEN   = 2'd1,
        EPOCH_BLUE    = 2'd2,
        EPOCH_INVALID = 2'd3
    } EpochT;

    typedef enum logic [1:0] {
        EX_RUNNING = 2'd0,
        EX_STALLED = 2'd1,
        EX_HALTED  = 2'd2
    } ExecuteStateT;

    typedef struct packed {
        rvwordT pc;
        rvwordT inst;
        EpochT  epoch;
    } FetchEntryT;

    typedef struct packed {
        rvwordT pc;
        EpochT  epoch;
    } FetchTagT;

    // Epoch colours rotate through the three valid values; INVALID never appears as a live epoch.
    function automatic EpochT nextEpochColour(input EpochT e);
        case (e)
            EPOCH_RED:   return EPOCH_GREEN;
            EPOCH_GREEN: return EPOCH_BLUE;
            default:     return EPOCH_RED;
        endcase
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response and fetch-output handshake bundle.
interface fetch_if;
    import fetch_pkg::*;

    logic   imem_req_valid;
    rvwordT imem_req_addr;
    logic   imem_req_ready;
    logic   imem_resp_valid;
    rvwordT imem_resp_data;

    logic   f_valid;
    logic   f_ready;
    rvwordT f_pc;
    rvwordT f_inst;
    EpochT  f_epoch;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output f_valid, f_pc, f_inst, f_epoch,
        input  f_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  f_valid, f_pc, f_inst, f_epoch,
        output f_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with flush; serves as both the request tag queue and the output buffer.
module fetch_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: credit-limited imem requests, epoch-tagged responses, output buffer.
// Optional build macro FETCH_TRACE_EN prints accepted requests and redirects.
module fetch
    import fetch_pkg::*;
#(
    parameter rvwordT      RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  rvwordT       jumpPC,
    input  EpochT        jumpEpoch,
    input  ExecuteStateT executeState,
    fetch_if.master      bus
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned TAG_W   = $bits(FetchTagT);
    localparam int unsigned ENTRY_W = $bits(FetchEntryT);

    rvwordT           pc;
    EpochT            epoch;
    FetchTagT         tag_in;
    FetchTagT         tag_head;
    FetchEntryT       buf_in;
    FetchEntryT       buf_head;
    logic             tag_full;
    logic             tag_empty;
    logic             buf_full;
    logic             buf_empty;
    logic [CNT_W-1:0] tag_count;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   in_use_c;
    logic             redirect_c;
    logic             req_valid_c;
    logic             accept_c;
    logic             resp_take_c;
    logic             buf_push_c;
    logic             buf_pop_c;

    // Issue/response control; a redirect suppresses issue, enqueue and dequeue in its cycle.
    always_comb begin
        redirect_c  = 1'b0;
        in_use_c    = '0;
        req_valid_c = 1'b0;
        accept_c    = 1'b0;
        resp_take_c = 1'b0;
        buf_push_c  = 1'b0;
        buf_pop_c   = 1'b0;
        tag_in      = '0;
        buf_in      = '0;

        redirect_c  = (jumpEpoch != EPOCH_INVALID);
        in_use_c    = {1'b0, tag_count} + {1'b0, buf_count};
        req_valid_c = !rst && (executeState == EX_RUNNING) && !redirect_c
                      && (in_use_c < (CNT_W + 1)'(DEPTH));
        accept_c    = req_valid_c && bus.imem_req_ready && !tag_full;
        resp_take_c = bus.imem_resp_valid && !tag_empty;
        buf_pop_c   = !buf_empty && bus.f_ready && !redirect_c;
        buf_push_c  = resp_take_c && (tag_head.epoch == epoch) && !redirect_c
                      && (!buf_full || buf_pop_c);

        tag_in.pc    = pc;
        tag_in.epoch = epoch;
        buf_in.pc    = tag_head.pc;
        buf_in.inst  = bus.imem_resp_data;
        buf_in.epoch = tag_head.epoch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            epoch <= EPOCH_RED;
        end else if (redirect_c) begin
            pc    <= jumpPC;
            epoch <= jumpEpoch;
        end else if (accept_c) begin
            pc    <= pc + 32'd4;
        end
    end

    // Tags survive a redirect so stale responses can still be matched and discarded.
    fetch_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_c),
        .push_data (tag_in),
        .pop       (resp_take_c),
        .flush     (1'b0),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push_c),
        .push_data (buf_in),
        .pop       (buf_pop_c),
        .flush     (redirect_c),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = pc;
    assign bus.f_valid        = !buf_empty;
    assign bus.f_pc           = buf_head.pc;
    assign bus.f_inst         = buf_head.inst;
    assign bus.f_epoch        = buf_head.epoch;

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!rst && accept_c)
            $display("%05t: fetch pc=0x%08x", $time, pc);
        if (!rst && redirect_c)
            $display("%05t: fetch redirect epoch %0d -> %0d", $time, epoch, jumpEpoch);
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: transaction-level queue model plus directed scenarios.
module tb_fetch;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam rvwordT      RESET_PC = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         rst;
    rvwordT       jumpPC;
    EpochT        jumpEpoch;
    ExecuteStateT executeState;

    fetch_if bus();

    fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .jumpPC       (jumpPC),
        .jumpEpoch    (jumpEpoch),
        .executeState (executeState),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%08x exp=0x%08x t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic rvwordT mem_word(input rvwordT a);
        return a ^ 32'h1357_9bdf;
    endfunction

    // imem environment: one-cycle latency, in-order responses, can be held off with resp_en.
    rvwordT pend_q[$];
    logic   resp_en;
    int     acc_cnt = 0;

    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            if (bus.imem_resp_valid && pend_q.size() != 0) void'(pend_q.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend_q.push_back(bus.imem_req_addr);
                acc_cnt++;
            end
            #2;
            bus.imem_resp_valid = resp_en && (pend_q.size() != 0);
            bus.imem_resp_data  = (pend_q.size() != 0) ? mem_word(pend_q[0]) : 32'h0;
        end
    end

    // Reference model: in-flight tags, expected buffer contents, and dequeued history.
    rvwordT     m_pc;
    EpochT      m_epoch;
    FetchEntryT infl_q[$];
    FetchEntryT exp_q[$];
    FetchEntryT seen[$];

    function automatic logic model_req_valid();
        return !rst && executeState == EX_RUNNING && jumpEpoch == EPOCH_INVALID
               && (infl_q.size() + exp_q.size() < int'(DEPTH));
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic       acc, redir, take, deq;
        FetchEntryT t;
        if (rst) begin
            infl_q.delete();
            exp_q.delete();
            m_pc    = RESET_PC;
            m_epoch = EPOCH_RED;
        end else begin
            redir = (jumpEpoch != EPOCH_INVALID);
            acc   = model_req_valid() && bus.imem_req_ready;
            take  = bus.imem_resp_valid && infl_q.size() != 0;
            deq   = exp_q.size() != 0 && bus.f_ready && !redir;
            if (deq) seen.push_back(exp_q.pop_front());
            if (take) begin
                t = infl_q.pop_front();
                if (t.epoch == m_epoch && !redir) begin
                    t.inst = bus.imem_resp_data;
                    exp_q.push_back(t);
                end
            end
            if (redir) begin
                exp_q.delete();
                m_pc    = jumpPC;
                m_epoch = jumpEpoch;
            end else if (acc) begin
                t.pc    = m_pc;
                t.inst  = 32'h0;
                t.epoch = m_epoch;
                infl_q.push_back(t);
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        chk("f_valid", 32'(bus.f_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("f_pc", bus.f_pc, exp_q[0].pc);
            chk("f_inst", bus.f_inst, exp_q[0].inst);
            chk("f_epoch", 32'(bus.f_epoch), 32'(exp_q[0].epoch));
        end
        chk("req_valid", 32'(bus.imem_req_valid), 32'(model_req_valid()));
        if (model_req_valid()) chk("req_addr", bus.imem_req_addr, m_pc);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string name, input int idx, input rvwordT pc, input EpochT ep);
        chk({name, "_present"}, 32'(idx < seen.size()), 32'd1);
        if (idx < seen.size()) begin
            chk({name, "_pc"}, seen[idx].pc, pc);
            chk({name, "_epoch"}, 32'(seen[idx].epoch), 32'(ep));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int     n, a0, blue_idx;
        rvwordT stale_pc;

        rst                = 1'b1;
        jumpPC             = '0;
        jumpEpoch          = EPOCH_INVALID;
        executeState       = EX_RUNNING;
        bus.imem_req_ready = 1'b1;
        bus.f_ready        = 1'b1;
        resp_en            = 1'b1;
        tick(2);

        // Reset values.
        chk("rst_f_valid", 32'(bus.f_valid), 32'd0);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_f_pc", bus.f_pc, 32'd0);
        chk("rst_f_inst", bus.f_inst, 32'd0);
        chk("rst_f_epoch", 32'(bus.f_epoch), 32'(EPOCH_RED));

        // First request in the first cycle after reset release.
        rst = 1'b0;
        #1;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, 32'h100);
        tick(12);
        check_entry("seq0", 0, 32'h100, EPOCH_RED);
        check_entry("seq1", 1, 32'h104, EPOCH_RED);
        check_entry("seq2", 2, 32'h108, EPOCH_RED);

        // Downstream stall: credit caps issue, then lossless in-order drain.
        bus.f_ready = 1'b0;
        a0 = acc_cnt;
        tick(10);
        chk("stall_reqs_le_depth", 32'((acc_cnt - a0) <= int'(DEPTH)), 32'd1);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("stall_f_valid", 32'(bus.f_valid), 32'd1);
        bus.f_ready = 1'b1;
        tick(12);
        for (int i = 0; i < seen.size(); i++) begin
            chk("drain_pc", seen[i].pc, 32'h100 + 32'(4 * i));
            chk("drain_epoch", 32'(seen[i].epoch), 32'(EPOCH_RED));
        end

        // Redirect with two requests in flight.
        resp_en = 1'b0;
        tick(6);
        chk("inflight_two", 32'(pend_q.size()), 32'd2);
        n = seen.size();
        jumpPC    = 32'h200;
        jumpEpoch = nextEpochColour(EPOCH_RED);
        tick(1);
        jumpEpoch = EPOCH_INVALID;
        resp_en   = 1'b1;
        tick(12);
        check_entry("redir1", n, 32'h200, EPOCH_GREEN);

        // Redirect coinciding with a response and a dequeue.
        resp_en = 1'b0;
        tick(6);
        bus.f_ready = 1'b0;
        resp_en     = 1'b1;
        tick(1);
        chk("pre_redir_f_valid", 32'(bus.f_valid), 32'd1);
        stale_pc    = pend_q[0];
        n           = seen.size();
        bus.f_ready = 1'b1;
        jumpPC      = 32'h300;
        jumpEpoch   = nextEpochColour(EPOCH_GREEN);
        tick(1);
        jumpEpoch = EPOCH_INVALID;
        chk("redir2_flushed", 32'(bus.f_valid), 32'd0);
        chk("redir2_no_deq", 32'(seen.size()), 32'(n));
        tick(12);
        blue_idx = n;
        check_entry("redir2", n, 32'h300, EPOCH_BLUE);
        for (int i = n; i < seen.size(); i++)
            chk("redir2_not_stale", 32'(seen[i].pc != stale_pc), 32'd1);

        // Execute stall: issue stops at once, outstanding work still delivers, resume is sequential.
        executeState = EX_STALLED;
        #1;
        chk("exstall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick(6);
        chk("exstall_drained", 32'(pend_q.size()), 32'd0);
        chk("exstall_f_valid", 32'(bus.f_valid), 32'd0);
        executeState = EX_RUNNING;
        tick(12);
        for (int i = blue_idx; i < seen.size(); i++)
            chk("resume_pc", seen[i].pc, 32'h300 + 32'(4 * (i - blue_idx)));

        // Reset with two requests outstanding; late responses must be ignored.
        resp_en = 1'b0;
        tick(6);
        chk("rst_pend_two", 32'(pend_q.size()), 32'd2);
        rst          = 1'b1;
        executeState = EX_STALLED;
        #1;
        chk("arst_f_valid", 32'(bus.f_valid), 32'd0);
        chk("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("arst_f_pc", bus.f_pc, 32'd0);
        chk("arst_f_epoch", 32'(bus.f_epoch), 32'(EPOCH_RED));
        tick(2);
        rst     = 1'b0;
        resp_en = 1'b1;
        tick(4);
        chk("late_resp_drained", 32'(pend_q.size()), 32'd0);
        chk("late_resp_ignored", 32'(bus.f_valid), 32'd0);
        n = seen.size();
        executeState = EX_RUNNING;
        #1;
        chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("post_rst_req_addr", bus.imem_req_addr, 32'h100);
        tick(8);
        check_entry("post_rst", n, 32'h100, EPOCH_RED);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2: output buffer entries and maximum outstanding imem requests; must be 2..4.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- jumpPC  in  rvwordT  redirect target from execute.
- jumpEpoch  in  EpochT  redirect epoch; EPOCH_INVALID means no redirect.
- executeState  in  ExecuteStateT  any value other than EX_RUNNING stops new issue.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  rvwordT  word-aligned fetch address.
- imem_req_ready  in  1  imem accepts request.
- imem_resp_valid  in  1  response data valid; responses return in order.
- imem_resp_data  in  rvwordT  instruction word.
- f_valid  out  1  buffer head valid.
- f_ready  in  1  downstream consumes head.
- f_pc, f_inst  out  rvwordT  head PC and instruction.
- f_epoch  out  EpochT  head epoch, feeds execute d_epoch.

Function
REQ-004 pc SHALL advance by 4 on each accepted request (imem_req_valid && imem_req_ready), wrapping modulo 2^32.
REQ-005 imem_req_valid SHALL be high iff executeState==EX_RUNNING, no redirect this cycle, and outstanding+occupancy < DEPTH.
REQ-006 Each accepted request SHALL push {pc, epoch} into an in-order tag queue of DEPTH entries.
REQ-007 Each imem_resp_valid SHALL pop the tag queue; if the tag epoch equals the current epoch, it pushes {tag pc, data, tag epoch} into the output buffer, otherwise it is dropped.
REQ-008 The response-to-f_valid latency SHALL be 1 cycle when the buffer is empty.
REQ-009 A head entry SHALL be dequeued on f_valid && f_ready; f_pc/f_inst/f_epoch SHALL hold stable while f_valid && !f_ready.
REQ-010 Simultaneous push and pop on a full buffer SHALL succeed.
- The credit rule in REQ-005 guarantees a response never arrives to a full buffer.
- imem_resp_valid with an empty tag queue SHALL be ignored.
REQ-011 On jumpEpoch != EPOCH_INVALID, at the next edge:
- pc <= jumpPC and epoch <= jumpEpoch;
- the output buffer is flushed;
- in-flight tags are kept, so their responses drain and are dropped per REQ-007;
- no request is issued in the redirect cycle.
REQ-012 A redirect coinciding with a response or dequeue SHALL take priority: that response is dropped and the flush wins.
REQ-013 jumpPC SHALL be used as given, without realignment.

Reset
REQ-014 While rst is high, and asynchronously on its assertion:
- pc=RESET_PC, epoch=EPOCH_RED;
- tag queue and buffer empty;
- imem_req_valid=0, f_valid=0;
- f_pc=0, f_inst=0, f_epoch=EPOCH_RED.
REQ-015 Reset asserted mid-transaction SHALL abandon all outstanding requests; responses arriving after deassertion with an empty tag queue are ignored.
REQ-016 The first request SHALL be issued in the first cycle after rst deasserts, provided executeState==EX_RUNNING.

Configuration
REQ-017 Macro FETCH_TRACE_EN:
- when defined, $display "%05t: fetch pc=0x%08x" on each accepted request, and a line with old and new epoch on each redirect;
- when undefined, no display statements are compiled and functional behaviour is identical.

Structure
REQ-018 The types package SHALL hold rvwordT, EpochT, EPOCH_RED, EPOCH_INVALID, nextEpochColour, ExecuteStateT, and a new FetchEntryT {pc, inst, epoch}.
REQ-019 A sub-module fetch_fifo (parameterised width and depth; push, pop, flush, full, empty, count) SHALL implement both the tag queue and the output buffer.

Verification
REQ-020 Reset with RESET_PC=0x100, imem 1-cycle latency, f_ready=1 -> f_pc sequence 0x100, 0x104, 0x108; all f_epoch=EPOCH_RED.
REQ-021 f_ready=0 for 10 cycles -> at most DEPTH requests issued, imem_req_valid low after that, head unchanged; then f_ready=1 -> in-order drain with no loss.
REQ-022 Redirect jumpPC=0x200, jumpEpoch=nextEpochColour(EPOCH_RED) with 2 requests in flight -> both stale responses dropped, next f_pc=0x200 with the new epoch.
REQ-023 Redirect in the same cycle as imem_resp_valid and f_ready -> buffer empty next cycle, and that response never appears.
REQ-024 executeState != EX_RUNNING -> imem_req_valid drops the same cycle while outstanding responses still deliver; back to EX_RUNNING -> issue resumes at the next sequential PC.
REQ-025 rst pulsed with 2 requests outstanding -> pc=RESET_PC, f_valid=0, late responses ignored.
